iris_layer_sequencer: RTL and testbench

Layer-by-layer scheduler for the Iris fixed-point network. It owns the `En`/`Run` control of every neuron layer and keeps every neuron on its fixed 7-state pass: LOAD, MULTIPLY, SHIFTING, ADD, ACTIVATION, RESULT, back to IDLE. It accepts one input sample per valid/ready handshake and fires the layers in order, strobing each inter-layer capture register. It then presents the result downstream under a valid/ready handshake. It also performs the mandatory post-reset bypass pass that moves neurons out of pipeline flush.

---
 rtl/iris_layer_sequencer.sv | 114 +++++++++++
 tb/tb_iris_layer_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/iris_layer_sequencer.sv
// rtl/iris_layer_sequencer.sv - layer-by-layer En/Run scheduler for the Iris fixed-point network
// Runs the post-reset bypass pass, then fires each layer once per accepted sample.
module iris_layer_sequencer #(
   parameter int NUM_LAYERS  = 3,
   parameter int PASS_CYCLES = 7,
   parameter int CNT_W       = 16,
   localparam int IW = $clog2(NUM_LAYERS) + 1,
   localparam int PW = $clog2(PASS_CYCLES + 1)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  In_Valid,
   output logic                  In_Ready,
   output logic                  Sample_Load,
   output logic [NUM_LAYERS-1:0] Layer_En,
   output logic                  Run,
   output logic [NUM_LAYERS-1:0] Cap,
   output logic [IW-1:0]         Layer_Idx,
   output logic                  Out_Valid,
   input  logic                  Out_Ready,
   output logic                  Busy,
   output logic [CNT_W-1:0]      Samples_Done
);

   typedef enum logic [2:0] {
      S_INIT,
      S_WARMUP,
      S_READY,
      S_RUN,
      S_DONE
   } state_t;

   state_t                state;
   logic [PW-1:0]         pc;
   logic [NUM_LAYERS-1:0] cap_r;
   logic [NUM_LAYERS-1:0] run_en;
   logic                  pc_last;
   logic                  idx_last;

   assign pc_last  = (pc == PW'(PASS_CYCLES - 1));
   assign idx_last = (Layer_Idx == IW'(NUM_LAYERS - 1));

   always_comb begin
      run_en = '0;
      for (int k = 0; k < NUM_LAYERS; k++) begin
         run_en[k] = (Layer_Idx == IW'(k));
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state        <= S_INIT;
         pc           <= '0;
         Layer_Idx    <= '0;
         Samples_Done <= '0;
         cap_r        <= '0;
      end else begin
         cap_r <= '0;
         case (state)
            S_INIT: begin
               state <= S_WARMUP;
               pc    <= '0;
            end
            S_WARMUP: begin
               if (pc_last) begin
                  state <= S_READY;
                  pc    <= '0;
               end else begin
                  pc <= pc + PW'(1);
               end
            end
            S_READY: begin
               if (In_Valid) begin
                  state     <= S_RUN;
                  Layer_Idx <= '0;
                  pc        <= '0;
               end
            end
            S_RUN: begin
               if (pc_last) begin
                  // Capture strobe lands on the cycle after the finishing layer's last pass cycle
                  cap_r <= run_en;
                  pc    <= '0;
                  if (idx_last) begin
                     state <= S_DONE;
                  end else begin
                     Layer_Idx <= Layer_Idx + IW'(1);
                  end
               end else begin
                  pc <= pc + PW'(1);
               end
            end
            S_DONE: begin
               if (Out_Ready) begin
                  Samples_Done <= Samples_Done + CNT_W'(1);
                  state        <= S_READY;
               end
            end
            default: state <= S_INIT;
         endcase
      end
   end

   // Enables drop to zero outside WARMUP/RUN so idle neurons never see En without Run
   assign In_Ready    = (state == S_READY);
   assign Sample_Load = (state == S_READY) && In_Valid;
   assign Layer_En    = (state == S_WARMUP) ? '1 :
                        (state == S_RUN)    ? run_en : '0;
   assign Run         = ((state == S_WARMUP) || (state == S_RUN)) && (pc == '0);
   assign Cap         = cap_r;
   assign Out_Valid   = (state == S_DONE);
   assign Busy        = (state != S_READY);

endmodule

// File: tb/tb_iris_layer_sequencer.sv
// tb/tb_iris_layer_sequencer.sv - directed self-checking bench for iris_layer_sequencer
module tb_iris_layer_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b0;
   logic       in_ready, sample_load, run, out_valid, busy;
   logic [2:0] layer_en, cap, layer_idx;
   logic [15:0] samples_done;

   logic       in_valid_w = 1'b0;
   logic       out_ready_w = 1'b0;
   logic       in_ready_w, sample_load_w, run_w, out_valid_w, busy_w;
   logic [2:0] layer_en_w, cap_w, layer_idx_w;
   logic [1:0] samples_done_w;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   iris_layer_sequencer dut (
      .clk(clk), .rst(rst), .In_Valid(in_valid), .In_Ready(in_ready),
      .Sample_Load(sample_load), .Layer_En(layer_en), .Run(run), .Cap(cap),
      .Layer_Idx(layer_idx), .Out_Valid(out_valid), .Out_Ready(out_ready),
      .Busy(busy), .Samples_Done(samples_done)
   );

   iris_layer_sequencer #(.CNT_W(2)) dut_w (
      .clk(clk), .rst(rst), .In_Valid(in_valid_w), .In_Ready(in_ready_w),
      .Sample_Load(sample_load_w), .Layer_En(layer_en_w), .Run(run_w), .Cap(cap_w),
      .Layer_Idx(layer_idx_w), .Out_Valid(out_valid_w), .Out_Ready(out_ready_w),
      .Busy(busy_w), .Samples_Done(samples_done_w)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_warmup();
      for (int i = 0; i < 7; i++) begin
         step();
         chk("warm_en", 32'(layer_en), 32'h7);
         chk("warm_run", 32'(run), (i == 0) ? 32'd1 : 32'd0);
         chk("warm_cap", 32'(cap), 32'd0);
         chk("warm_ovalid", 32'(out_valid), 32'd0);
         chk("warm_iready", 32'(in_ready), 32'd0);
      end
      step();
      chk("ready_iready", 32'(in_ready), 32'd1);
      chk("ready_busy", 32'(busy), 32'd0);
      chk("ready_en", 32'(layer_en), 32'd0);
   endtask

   initial begin
      int lay;
      int exp_cap;
      logic [1:0] wrap_exp [5];
      wrap_exp[0] = 2'd1; wrap_exp[1] = 2'd2; wrap_exp[2] = 2'd3;
      wrap_exp[3] = 2'd0; wrap_exp[4] = 2'd1;

      // Reset values
      step(); step();
      chk("rst_iready", 32'(in_ready), 32'd0);
      chk("rst_sload", 32'(sample_load), 32'd0);
      chk("rst_en", 32'(layer_en), 32'd0);
      chk("rst_run", 32'(run), 32'd0);
      chk("rst_cap", 32'(cap), 32'd0);
      chk("rst_ovalid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd1);
      chk("rst_idx", 32'(layer_idx), 32'd0);
      chk("rst_cnt", 32'(samples_done), 32'd0);

      // Release: one INIT cycle, then warmup
      rst = 1'b1;
      #1;
      chk("init_en", 32'(layer_en), 32'd0);
      chk("init_run", 32'(run), 32'd0);
      chk("init_busy", 32'(busy), 32'd1);
      chk_warmup();

      // Single sample with Out_Ready already high
      in_valid = 1'b1;
      out_ready = 1'b1;
      #1;
      chk("single_sload", 32'(sample_load), 32'd1);
      for (int c = 1; c <= 23; c++) begin
         step();
         if (c == 1) in_valid = 1'b0;
         if (c <= 21) begin
            lay = (c - 1) / 7;
            chk("single_en", 32'(layer_en), 32'(1 << lay));
            chk("single_idx", 32'(layer_idx), 32'(lay));
            chk("single_run", 32'(run), ((c - 1) % 7 == 0) ? 32'd1 : 32'd0);
         end else if (c == 22) begin
            chk("single_en_done", 32'(layer_en), 32'd0);
         end
         exp_cap = (c > 1 && (c - 1) % 7 == 0) ? (1 << ((c - 1) / 7 - 1)) : 0;
         chk("single_cap", 32'(cap), 32'(exp_cap));
         chk("single_ovalid", 32'(out_valid), (c == 22) ? 32'd1 : 32'd0);
         chk("single_sload_off", 32'(sample_load), 32'd0);
      end
      chk("single_iready", 32'(in_ready), 32'd1);
      chk("single_cnt", 32'(samples_done), 32'd1);

      // Back-pressure: In_Valid held high throughout, Out_Ready low for 10 DONE cycles
      in_valid = 1'b1;
      out_ready = 1'b0;
      #1;
      chk("bp_sload", 32'(sample_load), 32'd1);
      for (int c = 1; c <= 31; c++) begin
         step();
         if (c >= 22) begin
            chk("bp_ovalid", 32'(out_valid), 32'd1);
            chk("bp_en", 32'(layer_en), 32'd0);
            chk("bp_iready", 32'(in_ready), 32'd0);
            chk("bp_sload_off", 32'(sample_load), 32'd0);
            chk("bp_cnt_hold", 32'(samples_done), 32'd1);
         end
      end
      out_ready = 1'b1;
      in_valid = 1'b0;
      step();
      chk("bp_release_iready", 32'(in_ready), 32'd1);
      chk("bp_release_ovalid", 32'(out_valid), 32'd0);
      chk("bp_cnt", 32'(samples_done), 32'd2);

      // Back-to-back: accepts every 23 cycles
      in_valid = 1'b1;
      #1;
      chk("b2b_sload0", 32'(sample_load), 32'd1);
      for (int c = 1; c <= 68; c++) begin
         step();
         chk("b2b_sload", 32'(sample_load), (c % 23 == 0) ? 32'd1 : 32'd0);
         if (c % 23 == 0) chk("b2b_cnt", 32'(samples_done), 32'(2 + c / 23));
      end
      step();
      in_valid = 1'b0;
      #1;
      chk("b2b_iready", 32'(in_ready), 32'd1);
      chk("b2b_cnt_final", 32'(samples_done), 32'd5);

      // Reset during layer 1, pc=3
      in_valid = 1'b1;
      #1;
      for (int c = 1; c <= 11; c++) begin
         step();
         if (c == 1) in_valid = 1'b0;
      end
      chk("mid_en_before", 32'(layer_en), 32'd2);
      #2;
      rst = 1'b0;
      #1;
      chk("mid_en", 32'(layer_en), 32'd0);
      chk("mid_run", 32'(run), 32'd0);
      chk("mid_cap", 32'(cap), 32'd0);
      chk("mid_ovalid", 32'(out_valid), 32'd0);
      chk("mid_iready", 32'(in_ready), 32'd0);
      chk("mid_busy", 32'(busy), 32'd1);
      chk("mid_idx", 32'(layer_idx), 32'd0);
      chk("mid_cnt", 32'(samples_done), 32'd0);
      #1;
      rst = 1'b1;
      #1;
      chk_warmup();
      for (int c = 0; c < 20; c++) begin
         step();
         chk("post_cap", 32'(cap), 32'd0);
         chk("post_ovalid", 32'(out_valid), 32'd0);
      end

      // Counter wrap on the CNT_W=2 instance
      in_valid_w = 1'b1;
      out_ready_w = 1'b1;
      for (int c = 1; c <= 115; c++) begin
         step();
         if (c % 23 == 0) chk("wrap_cnt", 32'(samples_done_w), 32'(wrap_exp[c / 23 - 1]));
      end
      in_valid_w = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
